regfile_bypass: RTL and testbench

Parametrised general-purpose register file for the 5-stage pipeline: one synchronous write port (WB), NRD combinational read ports (ID), and EX/MEM/WB forwarding with youngest-wins priority. Adds several features: synchronous clear of all storage on reset, a configurable hard-wired zero register, and load-use hazard detection that raises a stall request to the pipeline controller. Sits between ID (read side) and WB (write side); forwarding inputs come from the EX and MEM stage outputs.

---
 rtl/regfile_bypass.sv | 132 +++++++++++++
 tb/tb_regfile_bypass.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_bypass.sv
// Register file with one WB write port, NRD combinational read ports and
// EX/MEM/WB forwarding (youngest producer wins). A load sitting in EX that
// matches an enabled read raises stall_req_o so the controller can bubble.

// Single read port: reset/enable gating, zero register, forwarding mux, hazard
module regfile_bypass_rdport #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1
) (
   input  logic              rst,
   input  logic              en_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic              ex_we_i,
   input  logic [ADDR_W-1:0] ex_waddr_i,
   input  logic [DATA_W-1:0] ex_wdata_i,
   input  logic              ex_is_load_i,
   input  logic              mem_we_i,
   input  logic [ADDR_W-1:0] mem_waddr_i,
   input  logic [DATA_W-1:0] mem_wdata_i,
   input  logic              wb_we_i,
   input  logic [ADDR_W-1:0] wb_waddr_i,
   input  logic [DATA_W-1:0] wb_wdata_i,
   input  logic [DATA_W-1:0] arr_data_i,
   output logic [DATA_W-1:0] data_o,
   output logic              hazard_o
);

   logic is_zero;
   assign is_zero = (ZERO_REG != 0) && (addr_i == '0);

   // Priority mux: EX beats MEM beats WB beats array; a matching EX load
   // returns 0 and flags the hazard instead of forwarding stale data
   always_comb begin
      data_o   = '0;
      hazard_o = 1'b0;
      if (!rst && en_i && !is_zero) begin
         if (ex_we_i && ex_waddr_i == addr_i) begin
            if (ex_is_load_i) hazard_o = 1'b1;
            else              data_o   = ex_wdata_i;
         end else if (mem_we_i && mem_waddr_i == addr_i) begin
            data_o = mem_wdata_i;
         end else if (wb_we_i && wb_waddr_i == addr_i) begin
            data_o = wb_wdata_i;
         end else begin
            data_o = arr_data_i;
         end
      end
   end

endmodule

module regfile_bypass #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NRD      = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wb_we_i,
   input  logic [ADDR_W-1:0]     wb_waddr_i,
   input  logic [DATA_W-1:0]     wb_wdata_i,
   input  logic                  mem_we_i,
   input  logic [ADDR_W-1:0]     mem_waddr_i,
   input  logic [DATA_W-1:0]     mem_wdata_i,
   input  logic                  ex_we_i,
   input  logic [ADDR_W-1:0]     ex_waddr_i,
   input  logic [DATA_W-1:0]     ex_wdata_i,
   input  logic                  ex_is_load_i,
   input  logic [NRD-1:0]        rd_en_i,
   input  logic [NRD*ADDR_W-1:0] rd_addr_i,
   output logic [NRD*DATA_W-1:0] rd_data_o,
   output logic                  stall_req_o
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
   logic [NRD-1:0][DATA_W-1:0]   arr_rd;
   logic [NRD-1:0][DATA_W-1:0]   port_data;
   logic [NRD-1:0]               port_hz;
   logic                         wr_en;

   // Writes to r0 are discarded when it is hard-wired to zero
   assign wr_en = wb_we_i && !((ZERO_REG != 0) && (wb_waddr_i == '0));

   // Next array state: at most one entry changes per cycle
   always_comb begin
      mem_d = mem_q;
      if (wr_en) mem_d[wb_waddr_i] = wb_wdata_i;
   end

   // Array update; reset clears every entry and drops a coincident WB write
   always_ff @(posedge clk) begin
      if (rst) mem_q <= '0;
      else     mem_q <= mem_d;
   end

   for (genvar g = 0; g < NRD; g++) begin : g_rd
      assign arr_rd[g] = mem_q[rd_addr_i[g*ADDR_W +: ADDR_W]];

      regfile_bypass_rdport #(
         .DATA_W   (DATA_W),
         .ADDR_W   (ADDR_W),
         .ZERO_REG (ZERO_REG)
      ) u_port (
         .rst          (rst),
         .en_i         (rd_en_i[g]),
         .addr_i       (rd_addr_i[g*ADDR_W +: ADDR_W]),
         .ex_we_i      (ex_we_i),
         .ex_waddr_i   (ex_waddr_i),
         .ex_wdata_i   (ex_wdata_i),
         .ex_is_load_i (ex_is_load_i),
         .mem_we_i     (mem_we_i),
         .mem_waddr_i  (mem_waddr_i),
         .mem_wdata_i  (mem_wdata_i),
         .wb_we_i      (wb_we_i),
         .wb_waddr_i   (wb_waddr_i),
         .wb_wdata_i   (wb_wdata_i),
         .arr_data_i   (arr_rd[g]),
         .data_o       (port_data[g]),
         .hazard_o     (port_hz[g])
      );

      assign rd_data_o[g*DATA_W +: DATA_W] = port_data[g];
   end

   // Ports already force their hazard low during reset
   assign stall_req_o = |port_hz;

endmodule

// File: tb/tb_regfile_bypass.sv
// Bench for regfile_bypass: instance A is the default 32x32, 2-port, zero-reg
// build; instance B is 64x64, 4-port with r0 as an ordinary register.
module tb_regfile_bypass;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit cmp_on = 1'b0;

   // ---------------- instance A signals ----------------
   logic        a_rst, a_wb_we, a_mem_we, a_ex_we, a_ex_ld;
   logic [4:0]  a_wb_waddr, a_mem_waddr, a_ex_waddr;
   logic [31:0] a_wb_wdata, a_mem_wdata, a_ex_wdata;
   logic [1:0]  a_rd_en;
   logic [9:0]  a_rd_addr;
   logic [63:0] a_rd_data;
   logic        a_stall;

   // ---------------- instance B signals ----------------
   logic        b_rst, b_wb_we, b_mem_we, b_ex_we, b_ex_ld;
   logic [5:0]  b_wb_waddr, b_mem_waddr, b_ex_waddr;
   logic [63:0] b_wb_wdata, b_mem_wdata, b_ex_wdata;
   logic [3:0]  b_rd_en;
   logic [23:0] b_rd_addr;
   logic [255:0] b_rd_data;
   logic        b_stall;

   regfile_bypass #(.DATA_W(32), .ADDR_W(5), .NRD(2), .ZERO_REG(1)) u_a (
      .clk(clk), .rst(a_rst),
      .wb_we_i(a_wb_we), .wb_waddr_i(a_wb_waddr), .wb_wdata_i(a_wb_wdata),
      .mem_we_i(a_mem_we), .mem_waddr_i(a_mem_waddr), .mem_wdata_i(a_mem_wdata),
      .ex_we_i(a_ex_we), .ex_waddr_i(a_ex_waddr), .ex_wdata_i(a_ex_wdata),
      .ex_is_load_i(a_ex_ld), .rd_en_i(a_rd_en), .rd_addr_i(a_rd_addr),
      .rd_data_o(a_rd_data), .stall_req_o(a_stall)
   );

   regfile_bypass #(.DATA_W(64), .ADDR_W(6), .NRD(4), .ZERO_REG(0)) u_b (
      .clk(clk), .rst(b_rst),
      .wb_we_i(b_wb_we), .wb_waddr_i(b_wb_waddr), .wb_wdata_i(b_wb_wdata),
      .mem_we_i(b_mem_we), .mem_waddr_i(b_mem_waddr), .mem_wdata_i(b_mem_wdata),
      .ex_we_i(b_ex_we), .ex_waddr_i(b_ex_waddr), .ex_wdata_i(b_ex_wdata),
      .ex_is_load_i(b_ex_ld), .rd_en_i(b_rd_en), .rd_addr_i(b_rd_addr),
      .rd_data_o(b_rd_data), .stall_req_o(b_stall)
   );

   // ---------------- reference model ----------------
   logic [31:0] ma [32] = '{default: '0};
   logic [63:0] mb [64] = '{default: '0};

   always @(posedge clk) begin
      if (a_rst) for (int k = 0; k < 32; k++) ma[k] <= '0;
      else if (a_wb_we && a_wb_waddr != 5'd0) ma[a_wb_waddr] <= a_wb_wdata;
      if (b_rst) for (int k = 0; k < 64; k++) mb[k] <= '0;
      else if (b_wb_we) mb[b_wb_waddr] <= b_wb_wdata;
   end

   // {hazard, data} a port of A must show
   function automatic logic [32:0] exp_a(input logic en, input logic [4:0] ad);
      if (a_rst || !en || ad == 5'd0)        return '0;
      if (a_ex_we && a_ex_waddr == ad)       return a_ex_ld ? {1'b1, 32'h0} : {1'b0, a_ex_wdata};
      if (a_mem_we && a_mem_waddr == ad)     return {1'b0, a_mem_wdata};
      if (a_wb_we && a_wb_waddr == ad)       return {1'b0, a_wb_wdata};
      return {1'b0, ma[ad]};
   endfunction

   function automatic logic [64:0] exp_b(input logic en, input logic [5:0] ad);
      if (b_rst || !en)                      return '0;
      if (b_ex_we && b_ex_waddr == ad)       return b_ex_ld ? {1'b1, 64'h0} : {1'b0, b_ex_wdata};
      if (b_mem_we && b_mem_waddr == ad)     return {1'b0, b_mem_wdata};
      if (b_wb_we && b_wb_waddr == ad)       return {1'b0, b_wb_wdata};
      return {1'b0, mb[ad]};
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h @%0t", nm, act, exp, $time);
      end
   endtask

   // Every-cycle comparison of both instances against the model
   always @(negedge clk) begin
      if (cmp_on) begin
         logic [32:0] ea;
         logic [64:0] eb;
         logic        hza, hzb;
         hza = 1'b0;
         hzb = 1'b0;
         for (int i = 0; i < 2; i++) begin
            ea = exp_a(a_rd_en[i], a_rd_addr[i*5 +: 5]);
            hza |= ea[32];
            check($sformatf("a_rd%0d", i), {32'h0, a_rd_data[i*32 +: 32]}, {32'h0, ea[31:0]});
         end
         check("a_stall", {63'h0, a_stall}, {63'h0, hza});
         for (int i = 0; i < 4; i++) begin
            eb = exp_b(b_rd_en[i], b_rd_addr[i*6 +: 6]);
            hzb |= eb[64];
            check($sformatf("b_rd%0d", i), b_rd_data[i*64 +: 64], eb[63:0]);
         end
         check("b_stall", {63'h0, b_stall}, {63'h0, hzb});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_a();
      a_wb_we = 0; a_mem_we = 0; a_ex_we = 0; a_ex_ld = 0;
      a_wb_waddr = 0; a_mem_waddr = 0; a_ex_waddr = 0;
      a_wb_wdata = 0; a_mem_wdata = 0; a_ex_wdata = 0;
      a_rd_en = 0; a_rd_addr = 0;
   endtask

   task automatic idle_b();
      b_wb_we = 0; b_mem_we = 0; b_ex_we = 0; b_ex_ld = 0;
      b_wb_waddr = 0; b_mem_waddr = 0; b_ex_waddr = 0;
      b_wb_wdata = 0; b_mem_wdata = 0; b_ex_wdata = 0;
      b_rd_en = 0; b_rd_addr = 0;
   endtask

   initial begin
      logic [63:0] v63;
      v63 = 64'h0123456789ABCDEF;
      idle_a(); idle_b();
      a_rst = 1; b_rst = 1;
      tick();
      a_rst = 0; b_rst = 0;
      cmp_on = 1;

      // ---- reset clears stored data; outputs quiet during reset ----
      a_wb_we = 1; a_wb_waddr = 5; a_wb_wdata = 32'hDEADBEEF;
      tick();
      a_wb_we = 0; a_rd_en = 2'b01; a_rd_addr = {5'd0, 5'd5};
      #2 check("rst_pre_r5", {32'h0, a_rd_data[31:0]}, 64'hDEADBEEF);
      tick();
      a_rst = 1; a_ex_we = 1; a_ex_waddr = 5; a_ex_wdata = 32'h99; a_ex_ld = 1;
      a_wb_we = 1; a_wb_waddr = 6; a_wb_wdata = 32'h66;
      a_rd_en = 2'b11; a_rd_addr = {5'd5, 5'd5};
      #2 check("rst_rd_data", a_rd_data, 64'h0);
      check("rst_stall", {63'h0, a_stall}, 64'h0);
      tick();
      idle_a(); a_rst = 0;
      a_rd_en = 2'b11; a_rd_addr = {5'd6, 5'd5};
      #2 check("rst_post_r5", {32'h0, a_rd_data[31:0]}, 64'h0);
      check("rst_dropped_wb", {32'h0, a_rd_data[63:32]}, 64'h0);

      // ---- forwarding priority ----
      tick();
      a_ex_we = 1;  a_ex_waddr = 1;  a_ex_wdata = 32'h33;
      a_mem_we = 1; a_mem_waddr = 1; a_mem_wdata = 32'h22;
      a_wb_we = 1;  a_wb_waddr = 1;  a_wb_wdata = 32'h11;
      a_rd_en = 2'b01; a_rd_addr = {5'd0, 5'd1};
      #2 check("prio_ex", {32'h0, a_rd_data[31:0]}, 64'h33);
      tick();
      a_ex_we = 0;
      #2 check("prio_mem", {32'h0, a_rd_data[31:0]}, 64'h22);
      tick();
      a_mem_we = 0;
      #2 check("prio_wb", {32'h0, a_rd_data[31:0]}, 64'h11);
      tick();
      a_wb_we = 0;
      #2 check("prio_array", {32'h0, a_rd_data[31:0]}, 64'h11);

      // ---- load-use hazard then MEM supplies data ----
      tick();
      a_ex_we = 1; a_ex_ld = 1; a_ex_waddr = 7; a_ex_wdata = 32'hBAD;
      a_rd_en = 2'b10; a_rd_addr = {5'd7, 5'd0};
      #2 check("lu_stall", {63'h0, a_stall}, 64'h1);
      check("lu_data", {32'h0, a_rd_data[63:32]}, 64'h0);
      tick();
      a_ex_we = 0; a_ex_ld = 0;
      a_mem_we = 1; a_mem_waddr = 7; a_mem_wdata = 32'hA5A5;
      #2 check("lu_release", {63'h0, a_stall}, 64'h0);
      check("lu_mem_data", {32'h0, a_rd_data[63:32]}, 64'hA5A5);

      // ---- hard-wired r0 ----
      tick();
      a_mem_we = 0;
      a_wb_we = 1; a_wb_waddr = 0; a_wb_wdata = 32'hFFFF;
      a_ex_we = 1; a_ex_waddr = 0; a_ex_wdata = 32'h1234; a_ex_ld = 1;
      a_rd_en = 2'b11; a_rd_addr = {5'd0, 5'd0};
      #2 check("z1_data", a_rd_data, 64'h0);
      check("z1_stall", {63'h0, a_stall}, 64'h0);
      tick();
      idle_a(); a_rd_en = 2'b01;
      #2 check("z1_array", {32'h0, a_rd_data[31:0]}, 64'h0);

      // ---- r0 ordinary on B ----
      tick();
      idle_a();
      b_wb_we = 1; b_wb_waddr = 0; b_wb_wdata = 64'hFFFF;
      tick();
      b_wb_we = 0; b_rd_en = 4'b0011; b_rd_addr = '0;
      #2 check("z0_array", b_rd_data[63:0], 64'hFFFF);
      b_ex_we = 1; b_ex_waddr = 0; b_ex_wdata = 64'h1234;
      #1 check("z0_fwd", b_rd_data[127:64], 64'h1234);
      b_ex_ld = 1;
      #1 check("z0_stall", {63'h0, b_stall}, 64'h1);

      // ---- wide data, four ports, disabled port ----
      tick();
      idle_b();
      b_wb_we = 1; b_wb_waddr = 63; b_wb_wdata = v63;
      tick();
      b_wb_we = 0; b_rd_en = 4'b1111; b_rd_addr = {4{6'd63}};
      #2;
      for (int i = 0; i < 4; i++)
         check($sformatf("mp_port%0d", i), b_rd_data[i*64 +: 64], v63);
      b_rd_en = 4'b1011;
      #1 check("mp_disabled", b_rd_data[191:128], 64'h0);
      check("mp_port3", b_rd_data[255:192], v63);

      // ---- random sweep, narrow address range to provoke matches ----
      for (int n = 0; n < 400; n++) begin
         tick();
         a_rst = ($urandom_range(0, 31) == 0);
         a_wb_we = 1'($urandom); a_mem_we = 1'($urandom); a_ex_we = 1'($urandom);
         a_ex_ld = ($urandom_range(0, 3) == 0);
         a_wb_waddr = 5'($urandom_range(0, 7)); a_mem_waddr = 5'($urandom_range(0, 7));
         a_ex_waddr = 5'($urandom_range(0, 7));
         a_wb_wdata = $urandom; a_mem_wdata = $urandom; a_ex_wdata = $urandom;
         a_rd_en = 2'($urandom);
         a_rd_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         b_rst = ($urandom_range(0, 31) == 0);
         b_wb_we = 1'($urandom); b_mem_we = 1'($urandom); b_ex_we = 1'($urandom);
         b_ex_ld = ($urandom_range(0, 3) == 0);
         b_wb_waddr = 6'($urandom_range(0, 7)); b_mem_waddr = 6'($urandom_range(0, 7));
         b_ex_waddr = 6'($urandom_range(0, 7));
         b_wb_wdata = {$urandom, $urandom}; b_mem_wdata = {$urandom, $urandom};
         b_ex_wdata = {$urandom, $urandom};
         b_rd_en = 4'($urandom);
         for (int i = 0; i < 4; i++) b_rd_addr[i*6 +: 6] = 6'($urandom_range(0, 7));
      end

      tick();
      idle_a(); idle_b(); a_rst = 0; b_rst = 0;
      tick();
      @(negedge clk);
      #1 cmp_on = 0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
